policy_gen_seq: RTL

Sequential, parametrised action selector for the Q-learning agent. It scans N_ACT Q-values one per cycle and returns the index of the largest Q-value among legal actions (the greedy pick). It can optionally replace that pick with a random legal action (epsilon-greedy) driven by an internal LFSR. It sits between the Q-table read port and the game-move logic and uses a start/done handshake.

---
 rtl/policy_pkg.sv | 20 ++
 rtl/lfsr16.sv | 26 ++
 rtl/policy_gen_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/policy_pkg.sv
// Shared types and defaults for the epsilon-greedy action selector.
package policy_pkg;

    localparam int unsigned DEF_Q_W   = 18;
    localparam int unsigned DEF_N_ACT = 9;
    localparam int unsigned DEF_IDX_W = 4;
    localparam int unsigned LFSR_W    = 16;

    // Galois feedback for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DECIDE,
        S_EXPLORE,
        S_DONE
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the exploration random source.
module lfsr16
    import policy_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign state = lfsr_q;

endmodule

// File: rtl/policy_gen_seq.sv
// Sequential epsilon-greedy action selector: scans one Q-value per cycle,
// picks the legal maximum and optionally swaps in a random legal action.
module policy_gen_seq
    import policy_pkg::*;
#(
    parameter int unsigned       Q_W       = DEF_Q_W,
    parameter int unsigned       N_ACT     = DEF_N_ACT,
    parameter int unsigned       IDX_W     = DEF_IDX_W,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_ACT*Q_W-1:0] q_flat,
    input  logic [N_ACT-1:0]     legal_mask,
    input  logic                 explore_en,
    input  logic [7:0]           eps_thresh,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     next_action,
    output logic                 action_valid,
    output logic                 explored,
    output logic [Q_W-1:0]       max_q
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ACT - 1);
    localparam logic [IDX_W-1:0] N_ACT_IDX = IDX_W'(N_ACT);

    state_t                  state_q, state_d;
    logic signed [Q_W-1:0]   q_q [N_ACT];
    logic signed [Q_W-1:0]   q_d [N_ACT];
    logic [N_ACT-1:0]        mask_q, mask_d;
    logic                    explore_q, explore_d;
    logic [7:0]              eps_q, eps_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic signed [Q_W-1:0]   best_q, best_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic                    have_best_q, have_best_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [IDX_W-1:0]        next_action_q, next_action_d;
    logic                    action_valid_q, action_valid_d;
    logic                    explored_q, explored_d;
    logic [Q_W-1:0]          max_q_q, max_q_d;

    logic [LFSR_W-1:0]       lfsr;
    logic [IDX_W-1:0]        raw_idx;
    logic [IDX_W-1:0]        start_idx;
    logic                    explore_hit;
    logic                    unused_lfsr_bits;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    // Folding the low LFSR bits into range needs one subtraction since 2^IDX_W < 2*N_ACT
    assign raw_idx          = lfsr[IDX_W-1:0];
    assign start_idx        = (raw_idx >= N_ACT_IDX) ? raw_idx - N_ACT_IDX : raw_idx;
    assign explore_hit      = explore_q && (lfsr[15:8] < eps_q);
    assign unused_lfsr_bits = ^lfsr[7:IDX_W];

    always_comb begin
        state_d        = state_q;
        q_d            = q_q;
        mask_d         = mask_q;
        explore_d      = explore_q;
        eps_d          = eps_q;
        idx_d          = idx_q;
        ptr_d          = ptr_q;
        best_d         = best_q;
        best_idx_d     = best_idx_q;
        have_best_d    = have_best_q;
        done_d         = 1'b0;
        next_action_d  = next_action_q;
        action_valid_d = action_valid_q;
        explored_d     = explored_q;
        max_q_d        = max_q_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < int'(N_ACT); i++) begin
                        q_d[i] = q_flat[i*Q_W +: Q_W];
                    end
                    mask_d      = legal_mask;
                    explore_d   = explore_en;
                    eps_d       = eps_thresh;
                    idx_d       = '0;
                    have_best_d = 1'b0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                // Strict greater-than keeps the lowest index on ties
                if (mask_q[idx_q] && (!have_best_q || (q_q[idx_q] > best_q))) begin
                    best_d      = q_q[idx_q];
                    best_idx_d  = idx_q;
                    have_best_d = 1'b1;
                end
                if (idx_q == LAST_IDX) state_d = S_DECIDE;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            S_DECIDE: begin
                action_valid_d = have_best_q;
                max_q_d        = have_best_q ? best_q : '0;
                explored_d     = 1'b0;
                if (!have_best_q) begin
                    next_action_d = '0;
                    state_d       = S_DONE;
                end else if (explore_hit) begin
                    ptr_d   = start_idx;
                    state_d = S_EXPLORE;
                end else begin
                    next_action_d = best_idx_q;
                    state_d       = S_DONE;
                end
            end
            S_EXPLORE: begin
                if (mask_q[ptr_q]) begin
                    next_action_d = ptr_q;
                    explored_d    = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < int'(N_ACT); i++) q_q[i] <= '0;
            mask_q         <= '0;
            explore_q      <= 1'b0;
            eps_q          <= '0;
            idx_q          <= '0;
            ptr_q          <= '0;
            best_q         <= '0;
            best_idx_q     <= '0;
            have_best_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            next_action_q  <= '0;
            action_valid_q <= 1'b0;
            explored_q     <= 1'b0;
            max_q_q        <= '0;
        end else begin
            state_q        <= state_d;
            q_q            <= q_d;
            mask_q         <= mask_d;
            explore_q      <= explore_d;
            eps_q          <= eps_d;
            idx_q          <= idx_d;
            ptr_q          <= ptr_d;
            best_q         <= best_d;
            best_idx_q     <= best_idx_d;
            have_best_q    <= have_best_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            next_action_q  <= next_action_d;
            action_valid_q <= action_valid_d;
            explored_q     <= explored_d;
            max_q_q        <= max_q_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign next_action  = next_action_q;
    assign action_valid = action_valid_q;
    assign explored     = explored_q;
    assign max_q        = max_q_q;

endmodule
